ovc_credit_status: RTL and testbench

Per-output-VC status and credit tracker for the router output side, directly downstream of the combined VC/switch allocator. It consumes the allocator's per-cycle OVC grants and the crossbar's sent-flit indications, and tracks downstream credits returned per OVC. From these it produces the registered `ovc_avalable_all`, `full_all` and `nearly_full_all` vectors. The router uses these vectors to build the masked OVC requests and the assigned-OVC-not-full signals that the allocator consumes next cycle.

---
 rtl/ovc_credit_status_pkg.sv | 40 ++++
 rtl/ovc_credit_status_if.sv | 35 +++
 rtl/ovc_credit_status_cell.sv | 97 +++++++++
 rtl/ovc_credit_status.sv | 61 ++++++
 tb/tb_ovc_credit_status.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/ovc_credit_status_pkg.sv
// Shared types, constants and helpers for the output-VC credit/status tracker.
package ovc_credit_status_pkg;

  // Ceiling log2. Returns the number of bits needed to index 'value' items.
  function automatic int unsigned log2(input int unsigned value);
    int unsigned n;
    n = 0;
    while ((64'd1 << n) < 64'(value)) n++;
    return n;
  endfunction

  // Router defaults: 4 VCs per port, 5 ports, 4-flit downstream buffers.
  localparam int unsigned V_DEF = 4;
  localparam int unsigned P_DEF = 5;
  localparam int unsigned B_DEF = 4;

  localparam int unsigned PV = V_DEF * P_DEF;
  localparam int unsigned Bw = log2(B_DEF + 1);

  // Bit positions in err_all.
  localparam int unsigned ERR_CRD_OVF    = 0;
  localparam int unsigned ERR_SEND_EMPTY = 1;
  localparam int unsigned ERR_DBL_ALLOC  = 2;
  localparam int unsigned ERR_W          = 3;

  // Credit counter action selected by the send/credit pulse pair.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_DEC  = 2'd1,
    CNT_INC  = 2'd2
  } cnt_op_e;

  // Per-cell error pulses, valid in the cycle the offending event arrives.
  typedef struct packed {
    logic dbl_alloc;
    logic send_empty;
    logic crd_ovf;
  } cell_err_t;

endpackage

// File: rtl/ovc_credit_status_if.sv
// Allocator/crossbar side bundle of the output-VC status tracker.
interface ovc_credit_status_if
  import ovc_credit_status_pkg::*;
#(
  parameter int unsigned PV = ovc_credit_status_pkg::PV,
  parameter int unsigned BW = ovc_credit_status_pkg::Bw
);

  logic [PV-1:0]    ovc_allocated_all;
  logic [PV-1:0]    flit_sent_all;
  logic [PV-1:0]    tail_sent_all;
  logic [PV-1:0]    credit_in_all;

  logic [PV-1:0]    ovc_avalable_all;
  logic [PV-1:0]    full_all;
  logic [PV-1:0]    nearly_full_all;
  logic [PV-1:0]    empty_all;
  logic [PV*BW-1:0] credit_count_all;
  logic [ERR_W-1:0] err_all;

  // Router side: issues grants, sent flits and returned credits.
  modport master (
    output ovc_allocated_all, flit_sent_all, tail_sent_all, credit_in_all,
    input  ovc_avalable_all, full_all, nearly_full_all, empty_all,
           credit_count_all, err_all
  );

  // Tracker side.
  modport slave (
    input  ovc_allocated_all, flit_sent_all, tail_sent_all, credit_in_all,
    output ovc_avalable_all, full_all, nearly_full_all, empty_all,
           credit_count_all, err_all
  );

endinterface

// File: rtl/ovc_credit_status_cell.sv
// One output VC: credit counter, ownership flag, registered status decode
// and single-cycle error pulses.
module ovc_status_cell
  import ovc_credit_status_pkg::*;
#(
  parameter int unsigned B            = 4,
  parameter int unsigned MIN_PCK_SIZE = 2,
  parameter int unsigned CW           = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alloc,
  input  logic          sent,
  input  logic          tail,
  input  logic          credit,
  output logic          avail,
  output logic          full,
  output logic          nearly_full,
  output logic          empty,
  output logic [CW-1:0] cnt,
  output cell_err_t     err
);

  localparam logic [CW-1:0] CNT_MAX = CW'(B);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          own_q, own_d;
  logic          tail_v;
  cnt_op_e       op;

  // A tail only counts when it rides on an actually sent flit.
  assign tail_v = sent & tail;

  // Send and credit in the same cycle cancel out, even at zero credit.
  always_comb begin
    unique case ({sent, credit})
      2'b10:   op = CNT_DEC;
      2'b01:   op = CNT_INC;
      default: op = CNT_HOLD;
    endcase
  end

  // Saturating credit counter next state and boundary errors.
  always_comb begin
    cnt_d          = cnt_q;
    err.crd_ovf    = 1'b0;
    err.send_empty = 1'b0;
    unique case (op)
      CNT_DEC: begin
        if (cnt_q == '0) err.send_empty = 1'b1;
        else             cnt_d = cnt_q - CNT_ONE;
      end
      CNT_INC: begin
        if (cnt_q == CNT_MAX) err.crd_ovf = 1'b1;
        else                  cnt_d = cnt_q + CNT_ONE;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Ownership: tail release wins over a same-cycle grant.
  always_comb begin
    own_d         = own_q;
    err.dbl_alloc = 1'b0;
    if (tail_v) begin
      own_d = 1'b0;
      if (alloc && (MIN_PCK_SIZE > 1)) err.dbl_alloc = 1'b1;
    end else if (alloc) begin
      own_d = 1'b1;
      if (own_q) err.dbl_alloc = 1'b1;
    end
  end

  // State and status flags; flags are decoded from next state so every
  // output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q       <= CNT_MAX;
      own_q       <= 1'b0;
      avail       <= 1'b1;
      full        <= 1'b0;
      nearly_full <= (CNT_MAX == CNT_ONE);
      empty       <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      own_q       <= own_d;
      avail       <= ~own_d;
      full        <= (cnt_d == '0);
      nearly_full <= (cnt_d == CNT_ONE);
      empty       <= (cnt_d == CNT_MAX) && !own_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ovc_credit_status.sv
// Per-output-VC status and credit tracker feeding the VC/switch allocator.
module ovc_credit_status
  import ovc_credit_status_pkg::*;
#(
  parameter int unsigned V            = 4,
  parameter int unsigned P            = 5,
  parameter int unsigned B            = 4,
  parameter int unsigned MIN_PCK_SIZE = 2
) (
  input  logic                clk,
  input  logic                reset,
  ovc_credit_status_if.slave  st
);

  localparam int unsigned NPV = V * P;
  localparam int unsigned CW  = log2(B + 1);

  cell_err_t        cell_err [NPV];
  logic [ERR_W-1:0] err_pulse;
  logic [ERR_W-1:0] err_q;

  for (genvar i = 0; i < NPV; i++) begin : g_cell
    ovc_status_cell #(
      .B            (B),
      .MIN_PCK_SIZE (MIN_PCK_SIZE),
      .CW           (CW)
    ) u_cell (
      .clk         (clk),
      .reset       (reset),
      .alloc       (st.ovc_allocated_all[i]),
      .sent        (st.flit_sent_all[i]),
      .tail        (st.tail_sent_all[i]),
      .credit      (st.credit_in_all[i]),
      .avail       (st.ovc_avalable_all[i]),
      .full        (st.full_all[i]),
      .nearly_full (st.nearly_full_all[i]),
      .empty       (st.empty_all[i]),
      .cnt         (st.credit_count_all[i*CW +: CW]),
      .err         (cell_err[i])
    );
  end

  // OR-reduce the per-cell error pulses into one pulse per error class.
  always_comb begin
    err_pulse = '0;
    for (int unsigned i = 0; i < NPV; i++) begin
      err_pulse[ERR_CRD_OVF]    = err_pulse[ERR_CRD_OVF]    | cell_err[i].crd_ovf;
      err_pulse[ERR_SEND_EMPTY] = err_pulse[ERR_SEND_EMPTY] | cell_err[i].send_empty;
      err_pulse[ERR_DBL_ALLOC]  = err_pulse[ERR_DBL_ALLOC]  | cell_err[i].dbl_alloc;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) err_q <= '0;
    else        err_q <= err_q | err_pulse;
  end

  assign st.err_all = err_q;

endmodule

// File: tb/tb_ovc_credit_status.sv
module tb_ovc_credit_status;

  localparam int V  = 4;
  localparam int P  = 5;
  localparam int B  = 4;
  localparam int PV = V * P;
  localparam int CW = 3;

  typedef enum int {
    K_CNT, K_AVAIL, K_FULL, K_NFULL, K_EMPTY, K_ERR,
    K_AVAIL_V, K_FULL_V, K_NFULL_V, K_EMPTY_V
  } kind_e;

  typedef struct {
    kind_e       kind;
    int          idx;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  ovc_credit_status_if #(.PV(PV), .BW(CW)) bus ();

  ovc_credit_status #(
    .V            (V),
    .P            (P),
    .B            (B),
    .MIN_PCK_SIZE (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .st    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [PV-1:0] b(input int i);
    logic [PV-1:0] one;
    one = 1;
    return one << i;
  endfunction

  function automatic logic [31:0] actual(input kind_e k, input int i);
    case (k)
      K_CNT:     return 32'(bus.credit_count_all[i*CW +: CW]);
      K_AVAIL:   return 32'(bus.ovc_avalable_all[i]);
      K_FULL:    return 32'(bus.full_all[i]);
      K_NFULL:   return 32'(bus.nearly_full_all[i]);
      K_EMPTY:   return 32'(bus.empty_all[i]);
      K_ERR:     return 32'(bus.err_all);
      K_AVAIL_V: return 32'(bus.ovc_avalable_all);
      K_FULL_V:  return 32'(bus.full_all);
      K_NFULL_V: return 32'(bus.nearly_full_all);
      default:   return 32'(bus.empty_all);
    endcase
  endfunction

  task automatic push(input kind_e k, input int i, input logic [31:0] v, input string n);
    exp_t e;
    e.kind = k; e.idx = i; e.val = v; e.name = n;
    sbq.push_back(e);
  endtask

  // Drive one cycle of pulses; returns #1 after the edge with inputs idle.
  task automatic step(input logic [PV-1:0] a, input logic [PV-1:0] s,
                      input logic [PV-1:0] t, input logic [PV-1:0] c,
                      input logic r);
    bus.ovc_allocated_all = a;
    bus.flit_sent_all     = s;
    bus.tail_sent_all     = t;
    bus.credit_in_all     = c;
    reset                 = r;
    @(posedge clk);
    #1;
    bus.ovc_allocated_all = '0;
    bus.flit_sent_all     = '0;
    bus.tail_sent_all     = '0;
    bus.credit_in_all     = '0;
    reset                 = 1'b1;
  endtask

  // Monitor: outputs are stable at the falling edge; compare everything queued.
  always begin
    exp_t        e;
    logic [31:0] act;
    @(negedge clk);
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      act = actual(e.kind, e.idx);
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s idx %0d: got %0h expected %0h", e.name, e.idx, act, e.val);
      end
    end
  end

  initial begin
    logic [PV-1:0] z;
    z = '0;
    bus.ovc_allocated_all = '0;
    bus.flit_sent_all     = '0;
    bus.tail_sent_all     = '0;
    bus.credit_in_all     = '0;
    reset                 = 1'b0;

    // Reset state
    step(z, z, z, z, 1'b0);
    for (int i = 0; i < PV; i++) push(K_CNT, i, 4, "rst_cnt");
    push(K_AVAIL_V, 0, 32'hFFFFF, "rst_avail");
    push(K_EMPTY_V, 0, 32'hFFFFF, "rst_empty");
    push(K_FULL_V,  0, 0, "rst_full");
    push(K_NFULL_V, 0, 0, "rst_nfull");
    push(K_ERR,     0, 0, "rst_err");

    // OVC 3: 3-flit packet
    step(b(3), z, z, z, 1'b1);
    push(K_AVAIL, 3, 0, "o3_alloc_avail");
    push(K_CNT,   3, 4, "o3_alloc_cnt");
    push(K_EMPTY, 3, 0, "o3_alloc_empty");
    step(z, b(3), z, z, 1'b1);
    push(K_CNT, 3, 3, "o3_f1_cnt");
    step(z, b(3), z, z, 1'b1);
    push(K_CNT,   3, 2, "o3_f2_cnt");
    push(K_NFULL, 3, 0, "o3_f2_nfull");
    push(K_AVAIL, 3, 0, "o3_f2_avail");
    step(z, b(3), b(3), z, 1'b1);
    push(K_CNT,   3, 1, "o3_tail_cnt");
    push(K_NFULL, 3, 1, "o3_tail_nfull");
    push(K_AVAIL, 3, 1, "o3_tail_avail");
    for (int k = 0; k < 3; k++) step(z, z, z, b(3), 1'b1);
    push(K_CNT,   3, 4, "o3_crd_cnt");
    push(K_EMPTY, 3, 1, "o3_crd_empty");
    push(K_NFULL, 3, 0, "o3_crd_nfull");
    push(K_ERR,   0, 0, "o3_err");

    // OVC 7: single-flit packet, tail-only ignored, double allocation
    step(b(7), b(7), b(7), z, 1'b1);
    push(K_AVAIL, 7, 1, "o7_single_avail");
    push(K_CNT,   7, 3, "o7_single_cnt");
    push(K_ERR,   0, 0, "o7_single_err");
    step(z, z, z, b(7), 1'b1);
    push(K_CNT, 7, 4, "o7_crd_cnt");
    step(b(7), z, z, z, 1'b1);
    push(K_AVAIL, 7, 0, "o7_alloc_avail");
    step(z, z, b(7), z, 1'b1);
    push(K_AVAIL, 7, 0, "o7_tailonly_avail");
    push(K_CNT,   7, 4, "o7_tailonly_cnt");
    step(b(7), z, z, z, 1'b1);
    push(K_ERR,   0, 3'b100, "o7_dbl_err");
    push(K_AVAIL, 7, 0, "o7_dbl_avail");
    step(z, b(7), b(7), z, 1'b1);
    push(K_AVAIL, 7, 1, "o7_rel_avail");
    push(K_CNT,   7, 3, "o7_rel_cnt");
    step(z, z, z, b(7), 1'b1);

    // OVC 0: drain credits, boundaries at both ends
    for (int k = 0; k < 4; k++) begin
      step(z, b(0), z, z, 1'b1);
      if (k == 2) begin
        push(K_CNT,   0, 1, "o0_s3_cnt");
        push(K_NFULL, 0, 1, "o0_s3_nfull");
        push(K_FULL,  0, 0, "o0_s3_full");
      end
    end
    push(K_CNT,   0, 0, "o0_s4_cnt");
    push(K_FULL,  0, 1, "o0_s4_full");
    push(K_NFULL, 0, 0, "o0_s4_nfull");
    step(z, b(0), z, b(0), 1'b1);
    push(K_CNT,  0, 0, "o0_sc0_cnt");
    push(K_FULL, 0, 1, "o0_sc0_full");
    push(K_ERR,  0, 3'b100, "o0_sc0_err");
    step(z, b(0), z, z, 1'b1);
    push(K_CNT, 0, 0, "o0_s5_cnt");
    push(K_ERR, 0, 3'b110, "o0_s5_err");
    for (int k = 0; k < 4; k++) step(z, z, z, b(0), 1'b1);
    push(K_CNT,   0, 4, "o0_c4_cnt");
    push(K_EMPTY, 0, 1, "o0_c4_empty");
    push(K_FULL,  0, 0, "o0_c4_full");
    step(z, z, z, b(0), 1'b1);
    push(K_CNT, 0, 4, "o0_ovf_cnt");
    push(K_ERR, 0, 3'b111, "o0_ovf_err");

    // OVC 5: reset in the middle of a packet, with traffic that cycle
    step(b(5), z, z, z, 1'b1);
    for (int k = 0; k < 3; k++) step(z, b(5), z, z, 1'b1);
    push(K_CNT,   5, 1, "o5_pre_cnt");
    push(K_AVAIL, 5, 0, "o5_pre_avail");
    step(z, b(5), z, b(1), 1'b0);
    push(K_CNT,     5, 4, "o5_rst_cnt");
    push(K_AVAIL,   5, 1, "o5_rst_avail");
    push(K_EMPTY,   5, 1, "o5_rst_empty");
    push(K_CNT,     1, 4, "o5_rst_cnt1");
    push(K_ERR,     0, 0, "o5_rst_err");
    push(K_AVAIL_V, 0, 32'hFFFFF, "o5_rst_avail_v");
    push(K_FULL_V,  0, 0, "o5_rst_full_v");

    // Let the monitor drain the scoreboard, bounded.
    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
